vending_fsm_param: RTL

Parametrised successor to the single-price candy vending FSM. It accumulates nickel, dime and quarter pulses into a credit register and vends once credit reaches PRICE. Any surplus is then returned as a sequence of nickel pulses. It adds cancel/refund, a credit cap with coin rejection, and a busy indication, and sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vending_pkg.sv | 23 ++
 rtl/vend_change_unit.sv | 37 +++
 rtl/vending_fsm_param.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state encoding and default coin/price constants
//
// Purpose: common definitions for vending_fsm_param and vend_change_unit.
// Contents: state_e (IDLE, COLLECT, VEND, CHANGE, REFUND) and default
//           parameter values in cents.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3,
    REFUND  = 3'd4
  } state_e;

  localparam int W_DEF           = 7;
  localparam int PRICE_DEF       = 25;
  localparam int NICKEL_VAL_DEF  = 5;
  localparam int DIME_VAL_DEF    = 10;
  localparam int QUARTER_VAL_DEF = 25;
  localparam int MAX_CREDIT_DEF  = 100;

endpackage

// File: rtl/vend_change_unit.sv
// rtl/vend_change_unit.sv - one-nickel-per-cycle payout step for CHANGE/REFUND
//
// Purpose: given the loaded credit, emits one NICKEL_VAL pulse per cycle while
//          active and computes the credit left after this pulse; done_o marks
//          the last pulse (credit exactly one nickel).
// Ports:
//   active_i       in  1  payout in progress (CHANGE or REFUND)
//   credit_i       in  W  credit still owed
//   pulse_o        out 1  one NICKEL_VAL returned this cycle
//   credit_next_o  out W  credit after this cycle's pulse
//   done_o         out 1  this is the final pulse
module vend_change_unit #(
  parameter int W          = 7,
  parameter int NICKEL_VAL = 5
) (
  input  logic         active_i,
  input  logic [W-1:0] credit_i,
  output logic         pulse_o,
  output logic [W-1:0] credit_next_o,
  output logic         done_o
);

  localparam logic [W-1:0] STEP = W'(NICKEL_VAL);

  always_comb begin
    pulse_o       = active_i;
    done_o        = 1'b0;
    credit_next_o = credit_i;
    if (active_i) begin
      // credit is always a nickel multiple here, so "<= STEP" is the last pulse
      // and also keeps a corrupted value from wrapping below zero.
      done_o        = (credit_i <= STEP);
      credit_next_o = done_o ? '0 : (credit_i - STEP);
    end
  end

endmodule

// File: rtl/vending_fsm_param.sv
// rtl/vending_fsm_param.sv - parametrised coin-accumulating vending FSM
//
// Purpose: sums coin pulses into a credit register, vends once credit reaches
//          PRICE, returns any surplus (or a cancelled credit) as nickel pulses,
//          and rejects coins that would exceed MAX_CREDIT or arrive while busy.
// Optional: define VENDING_VEND_COUNT_EN to add the 16-bit vend_count output.
// Ports:
//   clk          in  1   clock, rising edge
//   rst          in  1   asynchronous active-low reset
//   nickle       in  1   nickel pulse
//   dime         in  1   dime pulse
//   quater       in  1   quarter pulse
//   cancel       in  1   refund request pulse
//   candy        out 1   vend strobe (VEND state)
//   change_out   out 1   one NICKEL_VAL returned this cycle
//   coin_reject  out 1   previous cycle's coin sample was rejected
//   busy         out 1   VEND, CHANGE or REFUND
//   number_c     out W   current credit
//   vend_count   out 16  vends since reset (VENDING_VEND_COUNT_EN only)
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int PRICE       = PRICE_DEF,
  parameter int NICKEL_VAL  = NICKEL_VAL_DEF,
  parameter int DIME_VAL    = DIME_VAL_DEF,
  parameter int QUARTER_VAL = QUARTER_VAL_DEF,
  parameter int MAX_CREDIT  = MAX_CREDIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         nickle,
  input  logic         dime,
  input  logic         quater,
  input  logic         cancel,
  output logic         candy,
  output logic         change_out,
  output logic         coin_reject,
  output logic         busy,
`ifdef VENDING_VEND_COUNT_EN
  output logic [15:0]  vend_count,
`endif
  output logic [W-1:0] number_c
);

  // Two guard bits so credit + largest coin sample never truncates.
  localparam int SW = W + 2;
  localparam logic [SW-1:0] NICKEL_X  = SW'(NICKEL_VAL);
  localparam logic [SW-1:0] DIME_X    = SW'(DIME_VAL);
  localparam logic [SW-1:0] QUARTER_X = SW'(QUARTER_VAL);
  localparam logic [SW-1:0] PRICE_X   = SW'(PRICE);
  localparam logic [SW-1:0] MAX_X     = SW'(MAX_CREDIT);
  localparam logic [W-1:0]  PRICE_N   = W'(PRICE);

  state_e       state_q, state_d;
  logic [W-1:0] credit_q, credit_d;
  logic         reject_q, reject_d;

  logic [SW-1:0] coin_sum;
  logic [SW-1:0] sum_ext;
  logic          coin_present;
  logic          payout_active;
  logic [W-1:0]  payout_next;
  logic          payout_done;

  assign coin_sum     = (nickle ? NICKEL_X  : '0)
                      + (dime   ? DIME_X    : '0)
                      + (quater ? QUARTER_X : '0);
  assign sum_ext      = SW'(credit_q) + coin_sum;
  assign coin_present = (coin_sum != '0);
  assign payout_active = (state_q == CHANGE) || (state_q == REFUND);

  vend_change_unit #(
    .W          (W),
    .NICKEL_VAL (NICKEL_VAL)
  ) u_change (
    .active_i      (payout_active),
    .credit_i      (credit_q),
    .pulse_o       (change_out),
    .credit_next_o (payout_next),
    .done_o        (payout_done)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (coin_present) begin
          // A coin in the same cycle as cancel wins; cancel is dropped.
          if (sum_ext <= MAX_X) begin
            credit_d = sum_ext[W-1:0];
            state_d  = (sum_ext >= PRICE_X) ? VEND : COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end else if (cancel && (state_q == COLLECT)) begin
          state_d = REFUND;
        end
      end
      VEND: begin
        reject_d = coin_present;
        credit_d = credit_q - PRICE_N;
        // Any surplus, even >= PRICE, goes out as change: one vend only.
        state_d  = (credit_q > PRICE_N) ? CHANGE : IDLE;
      end
      CHANGE, REFUND: begin
        reject_d = coin_present;
        credit_d = payout_next;
        if (payout_done) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign candy       = (state_q == VEND);
  assign busy        = (state_q == VEND) || payout_active;
  assign coin_reject = reject_q;
  assign number_c    = credit_q;

`ifdef VENDING_VEND_COUNT_EN
  logic [15:0] vend_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vend_count_q <= '0;
    end else if (state_q == VEND) begin
      vend_count_q <= vend_count_q + 16'd1;
    end
  end

  assign vend_count = vend_count_q;
`endif

endmodule
